// File: rtl/mem_access_unit.sv
// RV32IM memory stage: aligned loads/stores over a ready handshake,
// with pipeline stall, access timeout and registered MEM/WB result.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] MEM_JAL_SELECTED,
  input  logic [31:0] MEM_READ_DATA2,
  input  logic [4:0]  MEM_RD,
  input  logic        MEM_MEM_WRITE,
  input  logic        MEM_MEM_READ,
  input  logic [2:0]  MEM_FUNC3,
  input  logic        MEM_WRITE_ENABLE,
  input  logic        MEM_DATA_MEM_SELECT,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_READY,
  output logic        MEM_STALL,
  output logic [31:0] WB_RESULT,
  output logic [4:0]  WB_RD,
  output logic        WB_WRITE_ENABLE,
  output logic        MISALIGNED,
  output logic        BUS_ERROR
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wd;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic        r_we, r_sel, r_st;

  logic        w_wait, w_l_acc, w_l_ok;
  logic [3:0]  w_l_be;
  logic [31:0] w_l_wd;
  logic [31:0] w_addr, w_wd, w_load, w_res;
  logic [3:0]  w_be;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic        w_we, w_sel, w_st;
  logic        w_req, w_fault, w_last, w_tmo, w_stall;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_wait  = (r_state == S_WAIT);
  assign w_l_acc = MEM_MEM_READ | MEM_MEM_WRITE;

  // Legality and store lane formatting from the live EX/MEM inputs
  always_comb begin
    w_l_ok = 1'b0;
    w_l_be = 4'b1111;
    w_l_wd = MEM_READ_DATA2;
    if (MEM_MEM_WRITE) begin
      case (MEM_FUNC3)
        3'b000: begin
          w_l_ok = 1'b1;
          w_l_be = 4'b0001 << MEM_JAL_SELECTED[1:0];
          w_l_wd = {4{MEM_READ_DATA2[7:0]}};
        end
        3'b001: begin
          w_l_ok = ~MEM_JAL_SELECTED[0];
          w_l_be = 4'b0011 << MEM_JAL_SELECTED[1:0];
          w_l_wd = {2{MEM_READ_DATA2[15:0]}};
        end
        3'b010: w_l_ok = (MEM_JAL_SELECTED[1:0] == 2'b00);
        default: w_l_ok = 1'b0;
      endcase
    end else begin
      case (MEM_FUNC3)
        3'b000, 3'b100: w_l_ok = 1'b1;
        3'b001, 3'b101: w_l_ok = ~MEM_JAL_SELECTED[0];
        3'b010: w_l_ok = (MEM_JAL_SELECTED[1:0] == 2'b00);
        default: w_l_ok = 1'b0;
      endcase
    end
  end

  // In WAIT only the latched copies are used; upstream may be garbage
  always_comb begin
    w_addr = MEM_JAL_SELECTED;
    w_wd   = w_l_wd;
    w_be   = w_l_be;
    w_f3   = MEM_FUNC3;
    w_rd   = MEM_RD;
    w_we   = MEM_WRITE_ENABLE;
    w_sel  = MEM_DATA_MEM_SELECT;
    w_st   = MEM_MEM_WRITE;
    if (w_wait) begin
      w_addr = r_addr;
      w_wd   = r_wd;
      w_be   = r_be;
      w_f3   = r_f3;
      w_rd   = r_rd;
      w_we   = r_we;
      w_sel  = r_sel;
      w_st   = r_st;
    end
  end

  assign w_req   = w_wait | (w_l_acc & w_l_ok);
  assign w_fault = ~w_wait & w_l_acc & ~w_l_ok;
  assign w_last  = (r_cnt == LAST);
  assign w_tmo   = w_wait & ~DMEM_READY & w_last;
  assign w_stall = w_req & ~DMEM_READY & ~w_tmo;

  assign DMEM_REQ   = w_req;
  assign DMEM_WE    = w_req & w_st;
  assign DMEM_ADDR  = {w_addr[31:2], 2'b00};
  assign DMEM_WDATA = w_wd;
  assign DMEM_BE    = w_st ? w_be : 4'b1111;
  assign MEM_STALL  = w_stall;

  always_comb begin
    case (w_addr[1:0])
      2'd0: w_byte = DMEM_RDATA[7:0];
      2'd1: w_byte = DMEM_RDATA[15:8];
      2'd2: w_byte = DMEM_RDATA[23:16];
      default: w_byte = DMEM_RDATA[31:24];
    endcase
    w_half = w_addr[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (w_f3)
      3'b000: w_load = {{24{w_byte[7]}}, w_byte};
      3'b001: w_load = {{16{w_half[15]}}, w_half};
      3'b100: w_load = {24'd0, w_byte};
      3'b101: w_load = {16'd0, w_half};
      default: w_load = DMEM_RDATA;
    endcase
    w_res = w_sel ? w_load : w_addr;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req && !DMEM_READY) w_next = S_WAIT;
      S_WAIT: if (DMEM_READY || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_wd            <= '0;
      r_be            <= '0;
      r_f3            <= '0;
      r_rd            <= '0;
      r_we            <= 1'b0;
      r_sel           <= 1'b0;
      r_st            <= 1'b0;
      WB_RESULT       <= '0;
      WB_RD           <= '0;
      WB_WRITE_ENABLE <= 1'b0;
      MISALIGNED      <= 1'b0;
      BUS_ERROR       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!w_wait) r_cnt <= '0;
      else if (!DMEM_READY && !w_last) r_cnt <= r_cnt + 1'b1;
      if (!w_wait && w_req && !DMEM_READY) begin
        r_addr <= MEM_JAL_SELECTED;
        r_wd   <= w_l_wd;
        r_be   <= w_l_be;
        r_f3   <= MEM_FUNC3;
        r_rd   <= MEM_RD;
        r_we   <= MEM_WRITE_ENABLE;
        r_sel  <= MEM_DATA_MEM_SELECT;
        r_st   <= MEM_MEM_WRITE;
      end
      MISALIGNED <= w_fault;
      BUS_ERROR  <= w_tmo;
      if (w_stall) begin
        WB_WRITE_ENABLE <= 1'b0;
      end else begin
        WB_RD           <= w_rd;
        WB_RESULT       <= w_res;
        WB_WRITE_ENABLE <= w_we & ~w_fault & ~w_tmo;
      end
    end
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the RV32IM pipeline. It sits between the EX/MEM pipeline register and the register-file writeback, and performs loads and stores against a variable-latency data memory through a request/ready handshake. It aligns store data with byte enables and sign- or zero-extends load data. It stalls the upstream pipeline while an access is outstanding, and registers the writeback result, destination and write enable (the MEM/WB boundary).

## Interface
- TIMEOUT, 16: maximum number of cycles spent in WAIT before the access is aborted with a bus error; minimum 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- MEM_JAL_SELECTED  in  32  byte address for load/store, or the result to pass through for non-memory instructions.
- MEM_READ_DATA2  in  32  store source data.
- MEM_RD  in  5  destination register.
- MEM_MEM_WRITE / MEM_MEM_READ  in  1 each  store / load request.
- MEM_FUNC3  in  3  access size/sign (RV32I encoding).
- MEM_WRITE_ENABLE  in  1  register writeback requested.
- MEM_DATA_MEM_SELECT  in  1  1 = writeback the load data, 0 = writeback MEM_JAL_SELECTED.
- DMEM_REQ  out  1  access request.
- DMEM_WE  out  1  1 = store.
- DMEM_ADDR  out  32  word-aligned address, bits [1:0] = 0.
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_BE  out  4  byte enables.
- DMEM_RDATA  in  32  read word, valid when DMEM_READY = 1.
- DMEM_READY  in  1  access complete this cycle.
- MEM_STALL  out  1  hold the upstream stages and EX/MEM.
- WB_RESULT  out  32  registered writeback data.
- WB_RD  out  5  registered destination.
- WB_WRITE_ENABLE  out  1  registered writeback enable.
- MISALIGNED  out  1  registered one-cycle fault pulse.
- BUS_ERROR  out  1  registered one-cycle timeout pulse.

## Operation
**Access classification**
- An access is requested when MEM_MEM_READ or MEM_MEM_WRITE is 1.
- If both are 1, the store wins.

**Legal func3 and alignment**
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Halfword accesses need addr[0] = 0; word accesses need addr[1:0] = 0.
- Any other func3, or a misaligned address, is a fault:
  - no DMEM_REQ and no stall;
  - the next edge writes MISALIGNED = 1 and WB_WRITE_ENABLE = 0.

**Store formatting**
- SB: DMEM_BE = 0001 << addr[1:0]; DMEM_WDATA = {4{data[7:0]}}.
- SH: DMEM_BE = 0011 << addr[1:0]; DMEM_WDATA = {2{data[15:0]}}.
- SW: DMEM_BE = 1111; DMEM_WDATA = data.
- Loads drive DMEM_BE = 1111.

**Load extraction**
- Select the byte/half lane from DMEM_RDATA using addr[1:0].
- Sign-extend for LB/LH; zero-extend for LBU/LHU.

**State machine: IDLE, WAIT**
- IDLE:
  - A legal access drives DMEM_REQ = 1 combinationally from the live inputs.
  - If DMEM_READY = 1 in the same cycle, the access completes with no stall.
  - Otherwise MEM_STALL = 1, and the FSM latches address, data, BE, func3, RD, write enable and select, then goes to WAIT. The counter clears to 0.
- WAIT:
  - DMEM_REQ = 1, driven from the latched copies.
  - DMEM_READY = 1: the access completes, MEM_STALL = 0, next state IDLE.
  - Otherwise the counter increments.
  - When the counter equals TIMEOUT-1 without ready: abort. MEM_STALL = 0, DMEM_REQ stays 1 this cycle, BUS_ERROR = 1 and WB_WRITE_ENABLE = 0 on the next edge, next state IDLE.

**WB register update (every edge, RST = 0)**
- MEM_STALL = 1: WB_WRITE_ENABLE <= 0 (bubble); WB_RESULT and WB_RD hold.
- Otherwise:
  - WB_RD <= rd.
  - WB_RESULT <= select ? extracted load data : MEM_JAL_SELECTED.
  - WB_WRITE_ENABLE <= write enable & ~fault & ~timeout.
- Non-memory instructions pass through in one cycle.

## Timing
- Reset: state IDLE, counter 0; WB_RESULT = 0, WB_RD = 0, WB_WRITE_ENABLE = 0, MISALIGNED = 0, BUS_ERROR = 0.
- Reset during WAIT: the FSM returns to IDLE on that edge, and the outstanding access is abandoned without BUS_ERROR.
- Zero-wait memory: WB outputs are valid one edge after the access cycle, and MEM_STALL never asserts.
- N wait cycles (ready in the Nth cycle after the first request): MEM_STALL = 1 for N cycles, and the result is registered on the edge closing the ready cycle.
- The upstream stage must hold its inputs while MEM_STALL = 1. In WAIT the block uses only the latched copies.
- The maximum stall is TIMEOUT cycles.
- MISALIGNED and BUS_ERROR are one-cycle pulses, never simultaneous.

## Test plan
- Zero-wait LW at 0x100, DMEM_RDATA = 0xDEADBEEF, rd = 5, select = 1 -> no stall; next edge WB_RESULT = 0xDEADBEEF, WB_RD = 5, WB_WRITE_ENABLE = 1.
- LB at 0x103, RDATA = 0x80FF_1234 -> WB_RESULT = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at 0x106, data 0x0000ABCD -> DMEM_ADDR = 0x104, DMEM_BE = 1100, DMEM_WDATA = 0xABCDABCD, DMEM_WE = 1.
- Ready after 3 wait cycles, with the inputs changed mid-wait -> MEM_STALL high for 3 cycles; DMEM_ADDR/WDATA keep the original values; WB_WRITE_ENABLE = 0 during the stall.
- LW at 0x102 -> no request, MISALIGNED pulse, WB_WRITE_ENABLE = 0. DMEM_READY held low -> stall lasts TIMEOUT = 16 cycles, then a BUS_ERROR pulse and the FSM returns to IDLE.
- RST asserted in the 2nd WAIT cycle -> next cycle IDLE, all outputs zero, no BUS_ERROR.
